// File: rtl/burst_ram_pkg.sv
// rtl/burst_ram_pkg.sv - shared types and default sizes for the burst RAM controller
package burst_ram_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 512;
  localparam int DEF_LEN_W  = 4;
  localparam int DEF_ADDR_W = $clog2(DEF_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  typedef struct packed {
    logic                  write;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_LEN_W-1:0]  len;
  } cmd_t;

endpackage

// File: rtl/burst_ram_mem.sv
// rtl/burst_ram_mem.sv - DEPTH x DATA_W storage array, one write port, one combinational read port
module burst_ram_mem
  import burst_ram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset so data survives a controller reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/burst_ram_ctrl.sv
// rtl/burst_ram_ctrl.sv - serial burst engine in front of the RAM; BURST_RAM_WRAP_EN makes addresses wrap modulo DEPTH
module burst_ram_ctrl
  import burst_ram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic              err
);

  state_t            state;
  logic [ADDR_W:0]   ptr;
  logic [ADDR_W:0]   ptr_inc;
  logic [LEN_W-1:0]  count;
  logic [LEN_W-1:0]  len_q;
  logic              err_q;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;

  assign cmd_ready = (state == IDLE);
  assign wr_ready  = (state == WRITE);
  assign busy      = (state != IDLE);

  // The extra top bit of ptr marks an out-of-range beat; with wrapping it never sets
`ifdef BURST_RAM_WRAP_EN
  assign ptr_inc = {1'b0, ptr[ADDR_W-1:0] + ADDR_W'(1)};
  assign err     = 1'b0;
`else
  assign ptr_inc = ptr + (ADDR_W+1)'(1);
  assign err     = err_q;
`endif

  // Out-of-range write beats are consumed but never reach the array
  assign mem_we    = wr_valid & wr_ready & ~ptr[ADDR_W];
  // In IDLE the read port looks ahead at the command address so the first beat is ready on entry to READ
  assign mem_raddr = (state == IDLE) ? cmd_addr : ptr_inc[ADDR_W-1:0];

  burst_ram_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (ptr[ADDR_W-1:0]),
    .wdata (wr_data),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  // Burst sequencing: command capture, write beats, registered read beats
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      count    <= '0;
      len_q    <= '0;
      err_q    <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            ptr   <= {1'b0, cmd_addr};
            count <= '0;
            len_q <= cmd_len;
            err_q <= 1'b0;
            if (cmd_write) begin
              state <= WRITE;
            end else begin
              state    <= READ;
              rd_valid <= 1'b1;
              rd_data  <= mem_rdata;
              rd_last  <= (cmd_len == '0);
            end
          end
        end
        WRITE: begin
          if (wr_valid) begin
            if (ptr[ADDR_W]) begin
              err_q <= 1'b1;
            end
            ptr   <= ptr_inc;
            count <= count + LEN_W'(1);
            if (count == len_q) begin
              state <= IDLE;
            end
          end
        end
        READ: begin
          if (rd_valid && rd_ready) begin
            if (rd_last) begin
              rd_valid <= 1'b0;
              rd_last  <= 1'b0;
              state    <= IDLE;
            end else begin
              ptr     <= ptr_inc;
              count   <= count + LEN_W'(1);
              rd_data <= ptr_inc[ADDR_W] ? '0 : mem_rdata;
              rd_last <= ((count + LEN_W'(1)) == len_q);
              if (ptr_inc[ADDR_W]) begin
                err_q <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
